// File: rtl/nway_d_cache_if.sv
// CPU-side and memory-side bus bundle for nway_d_cache.
// The slave modport is the cache's view; master is the requester/memory side.
interface nway_d_cache_if;
   logic [15:0]  mem_address;
   logic         mem_read;
   logic         mem_write;
   logic [1:0]   mem_byte_enable;
   logic [15:0]  mem_wdata;
   logic [15:0]  mem_rdata;
   logic         mem_resp;
   logic [15:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;
   logic [15:0]  hit_count;
   logic [15:0]  miss_count;
   logic [15:0]  wb_count;

   modport master (
      output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
             pmem_rdata, pmem_resp,
      input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write,
             pmem_wdata, hit_count, miss_count, wb_count
   );

   modport slave (
      input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
             pmem_rdata, pmem_resp,
      output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write,
             pmem_wdata, hit_count, miss_count, wb_count
   );
endinterface

// File: rtl/nway_d_cache.sv
// N-way set-associative write-back / write-allocate data cache with tree
// pseudo-LRU replacement, a three-state miss handler and saturating
// hit/miss/writeback counters.
module nway_d_cache #(
   parameter int WAYS = 2,
   parameter int SETS = 8
) (
   input logic          clk,
   input logic          rst_n,
   nway_d_cache_if.slave bus
);
   localparam int IDX = $clog2(SETS);
   localparam int TAG = 12 - IDX;
   localparam int LVL = $clog2(WAYS);
   localparam int WW  = (WAYS > 1) ? LVL : 1;
   localparam int PW  = (WAYS > 1) ? WAYS - 1 : 1;

   typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

   state_t          state_q, state_d;
   logic [127:0]    data_q  [WAYS][SETS];
   logic [TAG-1:0]  tag_q   [WAYS][SETS];
   logic [WAYS-1:0] valid_q [SETS];
   logic [WAYS-1:0] dirty_q [SETS];
   logic [PW-1:0]   plru_q  [SETS];
   logic [WW-1:0]   victim_q;
   logic            retry_q;
   logic [15:0]     hit_cnt_q, miss_cnt_q, wb_cnt_q;

   logic [IDX-1:0]  idx;
   logic [TAG-1:0]  tag;
   logic [2:0]      off;
   logic            req, is_wr;
   logic            unused_addr_bit;

   assign idx             = bus.mem_address[IDX+3:4];
   assign tag             = bus.mem_address[15:IDX+4];
   assign off             = bus.mem_address[3:1];
   assign req             = bus.mem_read | bus.mem_write;
   assign is_wr           = bus.mem_write;
   assign unused_addr_bit = bus.mem_address[0];

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [15:0] merge_word(input logic [15:0] old_w,
                                              input logic [15:0] new_w,
                                              input logic [1:0]  be);
      return {be[1] ? new_w[15:8] : old_w[15:8], be[0] ? new_w[7:0] : old_w[7:0]};
   endfunction

   // Walk root to leaf, pointing every node on the path away from 'way'.
   function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] cur,
                                                input logic [WW-1:0] way);
      logic [PW-1:0] nxt;
      int            node;
      int            dir;
      nxt  = cur;
      node = 0;
      for (int l = 0; l < LVL; l++) begin
         dir       = int'(way[LVL-1-l]);
         nxt[node] = (dir == 0);
         node      = 2 * node + 1 + dir;
      end
      return nxt;
   endfunction

   logic            hit;
   logic [WW-1:0]   hit_way;
   logic [WW-1:0]   victim;
   logic [127:0]    hit_line;
   logic            resp, pread, pwrite;
   logic [15:0]     paddr;
   logic [127:0]    pwdata;
   logic            hit_ev, miss_ev, wb_done, fill_done;

   // Parallel tag compare across all ways of the indexed set.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
            hit     = 1'b1;
            hit_way = WW'(w);
         end
      end
      hit_line = data_q[hit_way][idx];
   end

   // Victim: lowest-numbered invalid way, else follow the PLRU tree.
   always_comb begin
      int node;
      node = 0;
      for (int l = 0; l < LVL; l++) begin
         node = 2 * node + 1 + int'(plru_q[idx][node]);
      end
      victim = WW'(node - (WAYS - 1));
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[idx][w]) victim = WW'(w);
      end
   end

   // Miss-handler next state and bus outputs.
   always_comb begin
      state_d = state_q;
      resp    = 1'b0;
      pread   = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (hit) resp = 1'b1;
               else if (valid_q[idx][victim] && dirty_q[idx][victim]) state_d = WRITEBACK;
               else state_d = FILL;
            end
         end
         WRITEBACK: begin
            pwrite = 1'b1;
            paddr  = {tag_q[victim_q][idx], idx, 4'b0};
            pwdata = data_q[victim_q][idx];
            if (bus.pmem_resp) state_d = FILL;
         end
         FILL: begin
            pread = 1'b1;
            paddr = {tag, idx, 4'b0};
            if (bus.pmem_resp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign hit_ev    = (state_q == IDLE) && req && hit;
   assign miss_ev   = (state_q == IDLE) && req && !hit;
   assign wb_done   = (state_q == WRITEBACK) && bus.pmem_resp;
   assign fill_done = (state_q == FILL) && bus.pmem_resp;

   // Control state: FSM, valid/dirty/PLRU bookkeeping, victim latch, counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         victim_q   <= '0;
         retry_q    <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q <= state_d;
         if (hit_ev) begin
            plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
            if (is_wr) dirty_q[idx][hit_way] <= 1'b1;
            if (!retry_q) hit_cnt_q <= sat_inc(hit_cnt_q);
            retry_q <= 1'b0;
         end
         if (miss_ev) begin
            miss_cnt_q <= sat_inc(miss_cnt_q);
            victim_q   <= victim;
            retry_q    <= 1'b1;
         end
         if (wb_done) wb_cnt_q <= sat_inc(wb_cnt_q);
         if (fill_done) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
         end
      end
   end

   // Tag/data arrays: line fill or byte-merged write hit; frozen during reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (fill_done) begin
            data_q[victim_q][idx] <= bus.pmem_rdata;
            tag_q[victim_q][idx]  <= tag;
         end else if (hit_ev && is_wr) begin
            data_q[hit_way][idx][{off, 4'b0} +: 16] <=
               merge_word(hit_line[{off, 4'b0} +: 16], bus.mem_wdata, bus.mem_byte_enable);
         end
      end
   end

   assign bus.mem_resp     = resp;
   assign bus.mem_rdata    = resp ? hit_line[{off, 4'b0} +: 16] : 16'h0;
   assign bus.pmem_read    = pread;
   assign bus.pmem_write   = pwrite;
   assign bus.pmem_address = paddr;
   assign bus.pmem_wdata   = pwdata;
   assign bus.hit_count    = hit_cnt_q;
   assign bus.miss_count   = miss_cnt_q;
   assign bus.wb_count     = wb_cnt_q;
endmodule
